// File: rtl/ch_we_sequencer_if.sv
// Channel-select RAM write bus: strobe, address and data, driven by the sequencer.
// All signals are registered at the source and there is no backpressure.
interface ch_we_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  modport master (output ram_we, ram_addr, ram_din);
  modport slave  (input  ram_we, ram_addr, ram_din);
endinterface

// File: rtl/ch_we_sequencer.sv
// Turns a software command word into a burst of channel-select RAM writes.
// First write 3 edges after go rises; no backpressure, a go edge while busy is dropped and flagged.
module ch_we_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
) (
  input  logic                      user_clk,
  input  logic                      user_rst_n,
  input  logic [31:0]               reg_data,
  ch_we_sequencer_if.master         ram,
  output logic                      busy,
  output logic [15:0]               wr_count,
  output logic                      overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;
  localparam int LEN_LSB = DATA_W + ADDR_W;

  logic [31:0]       reg_q;
  logic              go_d;
  logic              clr_d;
  logic              go_edge;
  logic              clr_edge;
  logic [0:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              cur_inc;
  logic [7:0]        remaining;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              unused_reg_bits;

  assign unused_reg_bits = ^reg_q[27:20];

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      reg_q <= '0;
      go_d  <= 1'b0;
      clr_d <= 1'b0;
    end else begin
      reg_q <= reg_data;
      go_d  <= reg_q[31];
      clr_d <= reg_q[28];
    end
  end

  assign go_edge  = reg_q[31] & ~go_d;
  assign clr_edge = reg_q[28] & ~clr_d;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cur_data  <= '0;
      cur_inc   <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_edge) begin
            cur_addr  <= reg_q[LEN_LSB-1:DATA_W];
            cur_data  <= reg_q[DATA_W-1:0];
            cur_inc   <= reg_q[29];
            remaining <= reg_q[30] ? reg_q[LEN_LSB+7:LEN_LSB] : 8'd0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (remaining == 8'd0) begin
            state <= IDLE;
          end else begin
            remaining <= remaining - 8'd1;
            cur_addr  <= cur_addr + ADDR_W'(1);
            if (cur_inc) cur_data <= cur_data + DATA_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage lags the FSM by one edge; address/data hold between bursts.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ram_we_q   <= 1'b0;
      busy       <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      ram_we_q <= (state == WRITE);
      busy     <= (state == WRITE);
      if (state == WRITE) begin
        ram_addr_q <= cur_addr;
        ram_din_q  <= cur_data;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_count <= '0;
      overrun  <= 1'b0;
    end else begin
      if (clr_edge)
        wr_count <= '0;
      else if (ram_we_q && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;

      if (clr_edge)
        overrun <= 1'b0;
      else if (go_edge && state == WRITE)
        overrun <= 1'b1;
    end
  end

  assign ram.ram_we   = ram_we_q;
  assign ram.ram_addr = ram_addr_q;
  assign ram.ram_din  = ram_din_q;

endmodule

// File: tb/tb_ch_we_sequencer.sv
// Directed bench for ch_we_sequencer: a write-schedule model checked every cycle plus literal spot checks.
module tb_ch_we_sequencer;
  localparam int AW = 8;
  localparam int DW = 9;
  localparam int LL = AW + DW;

  localparam logic [31:0] GO   = 32'h8000_0000;
  localparam logic [31:0] FILL = 32'h4000_0000;
  localparam logic [31:0] INC  = 32'h2000_0000;
  localparam logic [31:0] CLR  = 32'h1000_0000;

  logic        user_clk;
  logic        user_rst_n;
  logic [31:0] reg_data;
  logic        busy;
  logic [15:0] wr_count;
  logic        overrun;

  ch_we_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  ch_we_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .reg_data   (reg_data),
    .ram        (ram_if),
    .busy       (busy),
    .wr_count   (wr_count),
    .overrun    (overrun)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int total = 0;
  int bad = 0;
  int obs_writes = 0;

  function automatic logic [31:0] cmd(input int addr, input int data, input int len);
    cmd = 32'((len << LL) | (addr << DW) | data);
  endfunction

  // Model: each accepted command expands into a table of (edge index -> addr/data) writes.
  logic [31:0] sched [int];
  logic [31:0] d1, d2;
  int          n;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  logic [15:0]   exp_cnt;
  logic          exp_ov;

  always @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      sched.delete();
      d1 = '0; d2 = '0; n = 0;
      exp_we = 1'b0; exp_addr = '0; exp_din = '0; exp_cnt = '0; exp_ov = 1'b0;
    end else begin
      logic ge, ce, fsm_busy;
      ge = d1[31] & ~d2[31];
      ce = d1[28] & ~d2[28];
      if (ce) exp_cnt = '0;
      else if (exp_we && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      fsm_busy = sched.exists(n);
      if (ge && !fsm_busy) begin
        int a0, v0, cnt;
        a0  = int'(d1[LL-1:DW]);
        v0  = int'(d1[DW-1:0]);
        cnt = d1[30] ? int'(d1[LL+7:LL]) + 1 : 1;
        for (int i = 0; i < cnt; i++) begin
          int a, v;
          a = (a0 + i) % (1 << AW);
          v = d1[29] ? (v0 + i) % (1 << DW) : v0;
          sched[n + 1 + i] = 32'((a << DW) | v);
        end
      end
      if (ce) exp_ov = 1'b0;
      else if (ge && fsm_busy) exp_ov = 1'b1;
      exp_we = sched.exists(n);
      if (exp_we) begin
        exp_addr = AW'(sched[n] >> DW);
        exp_din  = DW'(sched[n]);
        sched.delete(n);
      end
      d2 = d1;
      d1 = reg_data;
      n++;
    end
  end

  always @(negedge user_clk) begin
    total++;
    if (ram_if.ram_we !== exp_we || busy !== exp_we || ram_if.ram_addr !== exp_addr ||
        ram_if.ram_din !== exp_din || wr_count !== exp_cnt || overrun !== exp_ov) begin
      bad++;
      $display("FAIL cycle t=%0t: got we=%b busy=%b addr=%h din=%h cnt=%h ov=%b want we=%b addr=%h din=%h cnt=%h ov=%b",
               $time, ram_if.ram_we, busy, ram_if.ram_addr, ram_if.ram_din, wr_count, overrun,
               exp_we, exp_addr, exp_din, exp_cnt, exp_ov);
    end
    if (ram_if.ram_we === 1'b1) obs_writes++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w);
    @(negedge user_clk);
    reg_data = w;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy !== 1'b1 && i < 10) begin tick(); i++; end
    if (busy !== 1'b1) timeout(name);
    i = 0;
    while (busy !== 1'b0 && i < 400) begin tick(); i++; end
    if (busy !== 1'b0) timeout(name);
  endtask

  task automatic wait_writes(input string name, input int target);
    int i;
    i = 0;
    while (obs_writes < target && i < 400) begin tick(); i++; end
    if (obs_writes < target) timeout(name);
  endtask

  task automatic check_pair(input string name, input logic [AW-1:0] a, input logic [DW-1:0] v);
    chk({name, "_we"}, 32'(ram_if.ram_we), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_addr"}, 32'(ram_if.ram_addr), 32'(a));
    chk({name, "_din"}, 32'(ram_if.ram_din), 32'(v));
  endtask

  initial begin
    logic [AW-1:0] wa [4];
    logic [DW-1:0] wd [4];
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
    wd[0] = 9'h1FF; wd[1] = 9'h000; wd[2] = 9'h001; wd[3] = 9'h002;

    user_rst_n = 1'b0;
    reg_data   = '0;
    repeat (3) tick();
    chk("reset_we", 32'(ram_if.ram_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnt", 32'(wr_count), 32'd0);
    chk("reset_ov", 32'(overrun), 32'd0);
    @(negedge user_clk);
    user_rst_n = 1'b1;

    // single write, fill clear so len is ignored
    drive(GO | cmd(8'h12, 9'h0A5, 8'h55));
    repeat (2) tick();
    chk("single_early", 32'(ram_if.ram_we), 32'd0);
    tick();
    check_pair("single", 8'h12, 9'h0A5);
    tick();
    chk("single_done", 32'(ram_if.ram_we), 32'd0);
    chk("single_cnt", 32'(wr_count), 32'd1);
    chk("single_hold", 32'(ram_if.ram_addr), 32'h12);

    // fill + increment across both wrap points
    drive('0);
    drive(GO | FILL | INC | cmd(8'hFE, 9'h1FF, 3));
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check_pair($sformatf("wrap%0d", i), wa[i], wd[i]);
      tick();
    end
    chk("wrap_done", 32'(busy), 32'd0);
    chk("wrap_cnt", 32'(wr_count), 32'd5);

    // re-pulse go mid-burst
    drive('0);
    obs_writes = 0;
    drive(GO | FILL | cmd(0, 0, 8'hFF));
    wait_writes("ovr_start", 20);
    drive(FILL | cmd(0, 0, 8'hFF));
    repeat (2) tick();
    drive(GO | FILL | cmd(0, 0, 8'hFF));
    wait_idle("ovr_burst");
    repeat (3) tick();
    chk("ovr_writes", 32'(obs_writes), 32'd256);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cnt", 32'(wr_count), 32'd261);
    drive(CLR);
    repeat (3) tick();
    chk("clr_ov", 32'(overrun), 32'd0);
    chk("clr_cnt", 32'(wr_count), 32'd0);

    // clear edge lands on a write cycle
    drive('0);
    tick();
    obs_writes = 0;
    drive(GO | FILL | INC | cmd(8'h40, 9'h010, 7));
    wait_writes("coll_start", 3);
    drive(GO | CLR | FILL | INC | cmd(8'h40, 9'h010, 7));
    tick();
    chk("coll_we", 32'(ram_if.ram_we), 32'd1);
    tick();
    chk("coll_cnt0", 32'(wr_count), 32'd0);
    chk("coll_still", 32'(ram_if.ram_we), 32'd1);
    wait_idle("coll_burst");
    tick();
    chk("coll_writes", 32'(obs_writes), 32'd8);
    chk("coll_final", 32'(wr_count), 32'd3);

    // reset mid-burst
    drive('0);
    tick();
    obs_writes = 0;
    drive(GO | FILL | cmd(8'h20, 9'h033, 8'h3F));
    wait_writes("rst_start", 10);
    #1 user_rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(ram_if.ram_we), 32'd0);
    chk("rst_addr", 32'(ram_if.ram_addr), 32'd0);
    chk("rst_din", 32'(ram_if.ram_din), 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    reg_data = '0;
    repeat (2) tick();
    @(negedge user_clk);
    user_rst_n = 1'b1;
    obs_writes = 0;
    repeat (20) tick();
    chk("rst_noresume", 32'(obs_writes), 32'd0);

    // go already high when reset releases
    #1 user_rst_n = 1'b0;
    reg_data = GO | cmd(8'h33, 9'h044, 0);
    repeat (2) tick();
    @(negedge user_clk);
    user_rst_n = 1'b1;
    obs_writes = 0;
    repeat (20) tick();
    chk("rel_writes", 32'(obs_writes), 32'd1);
    chk("rel_addr", 32'(ram_if.ram_addr), 32'h33);
    chk("rel_din", 32'(ram_if.ram_din), 32'h044);

    // 65540 writes saturate the counter
    for (int k = 0; k < 257; k++) begin
      drive('0);
      drive(GO | FILL | cmd(0, 0, (k == 256) ? 3 : 8'hFF));
      wait_idle("sat_burst");
    end
    repeat (2) tick();
    chk("sat_cnt", 32'(wr_count), 32'hFFFF);
    chk("sat_ov", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ch_we_sequencer.md
CH_WE_SEQUENCER -- requirements
Module: ch_we_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: channel-select RAM address width (output slots).
REQ-002 Parameter DATA_W, default 9: channel-select RAM data width (FFT bin index). ADDR_W+DATA_W SHALL be <= 20.
REQ-003 user_clk  input  1  sole clock; all logic on rising edge.
REQ-004 user_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reg_data  input  32  software command word, user_clk domain, quasi-static.
REQ-006 ram_we  output  1  channel-select RAM write strobe.
REQ-007 ram_addr  output  ADDR_W  RAM write address.
REQ-008 ram_din  output  DATA_W  RAM write data.
REQ-009 busy  output  1  high while a command is executing.
REQ-010 wr_count  output  16  total RAM writes since reset or clear; saturating.
REQ-011 overrun  output  1  sticky; a go edge arrived while busy.

Function
REQ-012 Fields of reg_data SHALL be: data [DATA_W-1:0]; addr [DATA_W+ADDR_W-1:DATA_W]; len [DATA_W+ADDR_W+7:DATA_W+ADDR_W] (writes minus one); [28] clr; [29] inc; [30] fill; [31] go.
REQ-013 reg_data SHALL be registered once (reg_q), and go/clr registered again (go_d, clr_d) for edge detection.
REQ-014 A go edge is reg_q[31] & ~go_d. A clr edge is reg_q[28] & ~clr_d. Level-high go SHALL NOT retrigger.
REQ-015 FSM states SHALL be IDLE and WRITE only.
REQ-016 IDLE + go edge: latch addr, data, inc, and remaining = (fill ? len : 0); enter WRITE.
REQ-017 In WRITE: ram_we=1 for the current addr/data; if remaining==0 go to IDLE, else remaining-1, addr+1, data+1 when inc=1, else data held.
REQ-018 A command SHALL produce exactly remaining+1 consecutive ram_we cycles with no gaps.
REQ-019 addr increment SHALL wrap modulo 2^ADDR_W; data increment SHALL wrap modulo 2^DATA_W.
REQ-020 ram_we, ram_addr, ram_din, busy SHALL be registered outputs; busy=1 exactly in cycles where ram_we=1.
REQ-021 Latency: first ram_we cycle SHALL begin on the 3rd rising edge after reg_data[31] first meets setup high (edge 1 reg_q, edge 2 FSM, edge 3 output register).
REQ-022 ram_addr/ram_din SHALL hold their last values when ram_we=0.
REQ-023 A go edge detected while FSM is in WRITE SHALL be ignored and SHALL set overrun; the running command SHALL be unaffected.
REQ-024 A go edge on the same cycle the FSM returns to IDLE (remaining==0) SHALL be treated as busy: ignored, overrun set.
REQ-025 wr_count SHALL increment by 1 per ram_we cycle and saturate at 0xFFFF.
REQ-026 A clr edge SHALL zero wr_count and overrun; if a write occurs in the same cycle, the clear wins (count becomes 0, not 1).
REQ-027 clr SHALL NOT abort a running command.
REQ-028 fill=0 SHALL ignore len (single write).

Reset
REQ-029 On user_rst_n low, asynchronously: FSM=IDLE, ram_we=0, ram_addr=0, ram_din=0, busy=0, wr_count=0, overrun=0, reg_q=0, go_d=0, clr_d=0.
REQ-030 Reset mid-command SHALL terminate it immediately; after release, no write resumes until a new go edge.
REQ-031 If reg_data[31] is high at reset release, reg_q/go_d SHALL produce one go edge (go_d=0 at release), yielding one command.

Verification
REQ-032 Single: reg_data go=1, fill=0, addr=0x12, data=0x0A5 -> one ram_we cycle, addr 0x12, din 0x0A5, on edge 3; wr_count=1.
REQ-033 Fill+inc wrap: addr=0xFE, data=0x1FF, len=3, inc=1 -> 4 writes (addr,din) = (FE,1FF),(FF,000),(00,001),(01,002); busy 4 cycles.
REQ-034 Overrun: fill len=0xFF, re-pulse go during WRITE -> 256 writes only, overrun=1; then clr edge -> overrun=0, wr_count=0.
REQ-035 Saturation: issue 65540 writes -> wr_count holds 0xFFFF.
REQ-036 Reset abort: assert user_rst_n low at write 10 of len=0x3F -> all outputs 0 immediately; with go held low after release, no further ram_we.
REQ-037 Clear collision: clr edge coincident with a ram_we cycle -> wr_count=0 next cycle; remaining writes still complete.
